// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and the future transmitter.
//   rx_state_t      : receiver FSM encoding, 3 bits.
//   UART_OVERSAMPLE : default ticks per bit period.
//   UART_DATA_BITS  : default data bits per frame.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous level input.
// Both flops reset to 1, which is the idle level of a serial line.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset
//   d       : asynchronous input
//   q       : synchronised output (two clk of delay)
module uart_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (1 start, DATA_BITS data LSB first,
// optional parity, 1 stop). All state advances only on cycles with tick=1.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   tick       : one-clk enable at OVERSAMPLE x baud
//   rx         : asynchronous serial line, idle high
//   rx_data    : last correctly framed word
//   rx_valid   : one-clk strobe, rx_data updated in the same cycle
//   frame_err  : one-clk strobe, stop bit sampled low
//   busy       : FSM not in IDLE
// Optional (macro UART_RX_PARITY_EN):
//   parity_odd : 0 = even parity, 1 = odd parity
//   parity_err : one-clk strobe in the stop-decision cycle on mismatch
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  input  logic                 parity_odd,
  output logic                 parity_err
`endif
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TC_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_d;
  logic [TW-1:0]        tick_cnt, tick_cnt_d;
  logic [BW-1:0]        bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic [DATA_BITS-1:0] rx_data_d;
  logic                 armed, armed_d;
  logic                 rx_valid_d, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_bit_d;
  logic                 parity_err_d;
`endif

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      armed     <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      tick_cnt  <= tick_cnt_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      rx_data   <= rx_data_d;
      armed     <= armed_d;
      rx_valid  <= rx_valid_d;
      frame_err <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_bit_d;
      parity_err <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state;
    tick_cnt_d  = tick_cnt;
    bit_cnt_d   = bit_cnt;
    shreg_d     = shreg;
    rx_data_d   = rx_data;
    armed_d     = armed;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit;
    parity_err_d = 1'b0;
`endif
    if (tick) begin
      case (state)
        IDLE: begin
          // Arming requires a high sample first, so a held-low/break line
          // never re-triggers a frame.
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed) begin
            state_d    = START;
            tick_cnt_d = '0;
            armed_d    = 1'b0;
          end
        end
        START: begin
          if (tick_cnt == TC_MID) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
              armed_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt + TW'(1);
          end
        end
        DATA: begin
          tick_cnt_d = tick_cnt + TW'(1);
          if (tick_cnt == TC_LAST) begin
            shreg_d = {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt + BW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          tick_cnt_d = tick_cnt + TW'(1);
          if (tick_cnt == TC_LAST) begin
            par_bit_d = rx_s;
            state_d   = STOP;
          end
        end
`endif
        STOP: begin
          tick_cnt_d = tick_cnt + TW'(1);
          if (tick_cnt == TC_LAST) begin
            state_d = IDLE;
            if (rx_s) begin
              rx_data_d  = shreg;
              rx_valid_d = 1'b1;
              armed_d    = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            parity_err_d = ((^shreg) ^ par_bit) != parity_odd;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx in its default build
// (8 data bits, 16x oversample, no parity). tick pulses every 4 clk.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned DB = 8;
  localparam int unsigned OS = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, busy;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned div = 0;
  int unsigned ticks = 0;
  always @(posedge clk) begin
    div  <= (div == 3) ? 0 : div + 1;
    tick <= (div == 3);
    if (tick) ticks <= ticks + 1;
  end

  typedef struct {
    bit            err;
    logic [DB-1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  logic [DB-1:0] last_good = '0;
  bit          lat_check = 1'b0;
  int unsigned t0 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Each iteration stops on a falling edge where tick is high; that tick
  // is consumed by the DUT on the following rising edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(negedge clk); while (!tick);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    exp_t e;
    e.err  = !stop;
    e.data = stop ? d : last_good;
    if (stop) last_good = d;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < int'(DB); i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  always @(negedge clk) begin
    if (reset_n && (rx_valid || frame_err)) begin
      check("strobe_excl", {31'd0, rx_valid & frame_err}, 32'd0);
      check("expected_strobe", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind", {31'd0, frame_err}, {31'd0, e.err});
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
      end
      if (rx_valid) n_valid++;
      else n_ferr++;
      if (lat_check && rx_valid) begin
        // One tick is consumed before rx_s falls, then the first-low tick,
        // then OS/2 + (DB+1)*OS ticks to the stop decision.
        check("latency", ticks - t0, OS / 2 + (DB + 1) * OS + 2);
        lat_check = 1'b0;
      end
      @(negedge clk);
      check("busy_after", {31'd0, busy}, 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    wait_ticks(4);

    // 0xA5 with latency measurement
    t0 = ticks;
    lat_check = 1'b1;
    send_frame(8'hA5, 1'b1);
    wait_ticks(4);

    // Start glitch: low for 5 ticks, START check sees high and aborts
    rx = 1'b0;
    wait_ticks(5);
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    wait_ticks(8);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    wait_ticks(4);
    send_frame(8'h3C, 1'b1);
    wait_ticks(4);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_ticks(4);

    // Framing error then break; the receiver must stay disarmed
    send_frame(8'h3C, 1'b0);
    wait_ticks(40);
    check("break_busy", {31'd0, busy}, 32'd0);
    check("break_hold", {24'd0, rx_data}, {24'd0, last_good});
    rx = 1'b1;
    wait_ticks(4);

    // Reset in the middle of bit 3 of 0x81
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    wait_ticks(8);
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", {24'd0, rx_data}, 32'd0);
    check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    last_good = '0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(4);
    send_frame(8'h81, 1'b1);
    wait_ticks(8);

    check("sb_empty", sb.size(), 32'd0);
    check("n_valid", n_valid, 32'd5);
    check("n_ferr", n_ferr, 32'd1);
    check("final_data", {24'd0, rx_data}, 32'h81);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Sits directly downstream of baud_generator and consumes its `tick` output, a one-clock pulse at OVERSAMPLE × baud rate.
- Synchronises the asynchronous serial `rx` line and detects and validates the start bit. Samples each bit at mid-bit, LSB first, and checks the stop bit.
- Presents one received byte per frame with a single-cycle valid strobe to the host/FIFO side.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8 supported).
- OVERSAMPLE, 16, ticks per bit period; must be even and at least 4.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- tick  input  1  oversample enable from baud_generator, one clk wide.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  last correctly framed word.
- rx_valid  output  1  one-clk pulse; rx_data updated in the same cycle.
- frame_err  output  1  one-clk pulse; stop bit sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset is asynchronous and active-low (reset_n). Reset values: rx_data=0, rx_valid=0, frame_err=0, busy=0, FSM=IDLE, all counters=0, synchroniser flops=1.
- Synchroniser: `rx` passes through a 2-flop synchroniser giving rx_s. All FSM decisions use rx_s only.
- Timing rule: the FSM and all counters advance only on cycles with tick=1. Output strobes are driven on the clk edge that registers the deciding tick.
- tick_cnt is log2(OVERSAMPLE) bits wide and wraps at OVERSAMPLE-1. bit_cnt is log2(DATA_BITS) bits wide (minimum 1).
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the macro).
- IDLE:
  - Armed only after rx_s has been seen high on at least one tick since the last frame or since reset. This blocks re-triggering on a held-low or break line.
  - On a tick with rx_s=0 while armed: go to START and clear tick_cnt.
- START:
  - When tick_cnt reaches OVERSAMPLE/2-1, sample rx_s.
  - If rx_s=0: valid start; go to DATA, clear tick_cnt and bit_cnt.
  - If rx_s=1: glitch; return to IDLE with no strobes.
- DATA:
  - Sample rx_s when tick_cnt=OVERSAMPLE-1, i.e. at mid-bit.
  - Shift the sample into the MSB of the shift register (right shift), so data is LSB first.
  - After DATA_BITS samples, go to STOP (or to PARITY under the macro).
- STOP:
  - Sample rx_s at tick_cnt=OVERSAMPLE-1.
  - If rx_s=1: rx_data<=shift register, pulse rx_valid.
  - If rx_s=0: pulse frame_err; rx_data is held unchanged and disarmed.
  - Either way, go to IDLE in the same cycle.
- Latency: rx_valid pulses OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks after the first tick that sees rx_s low. With defaults that is 152 ticks, plus 2 clk of synchroniser delay relative to the raw rx edge.
- Back-to-back frames: because the decision is made at mid-stop-bit and rx_s is high there, IDLE is armed immediately. A start edge arriving half a bit later is caught with no frame lost.
- busy is high from entry to START until the cycle the FSM returns to IDLE.
- rx_valid and frame_err are never high in the same cycle.
- tick held low freezes the FSM indefinitely; no timeout.
- Reset asserted mid-frame: immediate return to reset state. The partial word is discarded and no strobe is issued.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds input `parity_odd` (1 bit; 0=even, 1=odd) and output `parity_err` (1-clk pulse, reset 0).
  - PARITY state sits between DATA and STOP and samples one bit at mid-bit.
  - Mismatch pulses parity_err in the STOP-decision cycle. rx_valid still pulses if the stop bit is good, and rx_data is updated.
  - Latency grows by OVERSAMPLE ticks.
- Undefined: no PARITY state and no parity ports. The frame is 1 start bit, DATA_BITS data bits and 1 stop bit.

Decomposition:
- Package uart_pkg holds:
  - the rx state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), 3 bits;
  - default OVERSAMPLE=16 and DATA_BITS=8 constants, shared with the future uart_tx.
- One sub-module: uart_sync2, a 2-flop synchroniser with reset value 1, reusable for other asynchronous inputs.

Test Plan:
- Common stimulus: tick modelled as a pulse every 4 clk, so one bit = 64 clk.
- Frame 0xA5, stop=1 → rx_data=0xA5, one rx_valid pulse 152 ticks after the start edge, frame_err=0, busy low the following cycle.
- rx low for 5 ticks then high (glitch) → no rx_valid and no frame_err; busy returns to 0 at the start-check tick; the next 0x3C frame is received correctly.
- Frame 0x3C with stop=0, then line held low for 40 ticks → one frame_err pulse; rx_data keeps its previous value; no new frame starts until rx returns high.
- Back-to-back 0x00 then 0xFF with no idle gap → two rx_valid pulses with rx_data=0x00 then 0xFF.
- reset_n pulsed low during bit 3 of 0x81 → outputs return to reset values; a following 0x81 frame is received correctly.
- With UART_RX_PARITY_EN defined and parity_odd=0: 0x07 with parity bit 1 → rx_valid, no parity_err; 0x07 with parity bit 0 → rx_valid and parity_err pulse together.
